// File: rtl/sort_stream_if.sv
// Stream bundle for sort_stream: input word stream in, sorted word stream out.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready close each valid/ready handshake.
interface sort_stream_if #(
  parameter int WIDTH = 8
);

  // Producer -> sorter
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  // Sorter -> consumer
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  // Sorter side
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  // Producer/consumer side
  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sort_stream.sv
// Streaming frame sorter: load up to DEPTH words, odd-even transposition sort, drain in order.
// Latency: DEPTH+1 cycles from the frame-ending input transfer to the first output word.
// Backpressure: in_ready only in LOAD; output word/last held stable while out_valid && !out_ready.
// Build option SORT_DESC_EN: descending order with all-zeros pad (default ascending, all-ones pad).
module sort_stream #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  sort_stream_if.slave   s,
  output logic           busy
);

  // Slot index width; a count never exceeds DEPTH, a slot index never exceeds DEPTH-1.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Pad value fills unused slots so they sort behind every real word.
`ifdef SORT_DESC_EN
  localparam logic [WIDTH-1:0] PAD = '0;
`else
  localparam logic [WIDTH-1:0] PAD = '1;
`endif

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;     // words in the current frame
  logic [CW-1:0]    stage_q, stage_d;     // sort stage index k
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;   // slot currently presented on out_data
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [WIDTH-1:0] sorted [DEPTH];       // slots after this cycle's exchange stage

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;

  logic             in_acc;
  logic             out_acc;
  logic [CW-1:0]    nxt_ptr;

  // True when the pair (a at lower index, b at higher index) must be exchanged.
  // Ties never swap, which keeps the network stable for equal keys.
  function automatic logic out_of_order(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
`ifdef SORT_DESC_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  assign in_acc  = s.in_valid && (state_q == LOAD);
  assign out_acc = out_valid_q && s.out_ready;
  assign nxt_ptr = rd_ptr_q + ONE;

  // One odd-even transposition stage: even pairs on even k, odd pairs on odd k.
  always_comb begin
    sorted = slot_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if ((((i % 2) != 0) == stage_q[0]) && out_of_order(slot_q[i], slot_q[i+1])) begin
        sorted[i]   = slot_q[i+1];
        sorted[i+1] = slot_q[i];
      end
    end
  end

  // Next-state and output-register logic for LOAD -> SORT -> DRAIN.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    stage_d     = stage_q;
    rd_ptr_d    = rd_ptr_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      LOAD: begin
        if (in_acc) begin
          slot_d[count_q[AW-1:0]] = s.in_data;
          count_d                 = count_q + ONE;
          // Frame ends on in_last or when the last free slot is filled.
          if (s.in_last || (count_q == LAST_IDX)) begin
            state_d = SORT;
            stage_d = '0;
          end
        end
      end

      SORT: begin
        slot_d  = sorted;
        stage_d = stage_q + ONE;
        // DEPTH stages fully sort any DEPTH-entry array; present slot 0 straight from the last stage.
        if (stage_q == LAST_IDX) begin
          state_d     = DRAIN;
          rd_ptr_d    = '0;
          out_valid_d = 1'b1;
          out_data_d  = sorted[0];
          out_last_d  = (count_q == ONE);
        end
      end

      DRAIN: begin
        if (out_acc) begin
          if (rd_ptr_q == count_q - ONE) begin
            // Final word taken: clear the frame and reopen the input next cycle.
            state_d     = LOAD;
            count_d     = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
              slot_d[i] = PAD;
            end
          end else begin
            rd_ptr_d   = nxt_ptr;
            out_data_d = slot_q[nxt_ptr[AW-1:0]];
            out_last_d = (nxt_ptr == count_q - ONE);
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and refills the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      stage_q     <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= PAD;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stage_q     <= stage_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      slot_q      <= slot_d;
    end
  end

  assign s.in_ready  = (state_q == LOAD);
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign busy        = (state_q != LOAD);

  // A stalled output word must not move or vanish.
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !s.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_last_q)));

  // Nothing is presented while the frame is still being sorted or loaded.
  a_no_out_outside_drain: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != DRAIN) |-> !out_valid_q);

endmodule
